// File: rtl/aes_block_loader.sv
// Byte-serial loader: assembles 16 bytes into a typed 128-bit block for key
// expansion / cipher datapath, flagging framing errors on the way.
module aes_block_loader #(
  parameter logic [1:0]  TYPE_KEY  = 2'b10,
  parameter logic [1:0]  TYPE_DATA = 2'b01,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             din_first,
  input  logic [1:0]       din_type,
  output logic             din_ready,
  output logic [127:0]     blk_out,
  output logic [1:0]       blk_type,
  output logic             blk_valid,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [127:0]       asm_q, asm_d;
  logic [1:0]         type_q, type_d;
  logic [127:0]       blk_out_d;
  logic [1:0]         blk_type_d;
  logic               blk_valid_d;
  logic               err_d;
  logic [CNT_W-1:0]   blk_count_d;
  logic               accept;
  logic               type_legal;
  logic [6:0]         byte_lsb;

  assign din_ready  = (state_q != EMIT);
  assign accept     = din_valid && din_ready;
  assign type_legal = (din_type == TYPE_KEY) || (din_type == TYPE_DATA);
  assign byte_lsb   = {cnt_q, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      asm_q     <= 128'd0;
      type_q    <= 2'b00;
      blk_out   <= 128'd0;
      blk_type  <= 2'b00;
      blk_valid <= 1'b0;
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      type_q    <= type_d;
      blk_out   <= blk_out_d;
      blk_type  <= blk_type_d;
      blk_valid <= blk_valid_d;
      err       <= err_d;
      blk_count <= blk_count_d;
    end
  end

  // Next-state and registered-output logic; the block is published on the
  // same edge that accepts byte 15, so blk_valid is high during EMIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    type_d      = type_q;
    blk_out_d   = blk_out;
    blk_type_d  = blk_type;
    blk_valid_d = 1'b0;
    err_d       = 1'b0;
    blk_count_d = blk_count;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (din_first && type_legal) begin
            asm_d[7:0] = din;
            type_d     = din_type;
            cnt_d      = 4'd1;
            state_d    = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (din_first) begin
            err_d = 1'b1;
            if (type_legal) begin
              asm_d[7:0] = din;
              type_d     = din_type;
              cnt_d      = 4'd1;
            end else begin
              cnt_d   = 4'd0;
              state_d = IDLE;
            end
          end else if (din_type != type_q) begin
            err_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            asm_d[byte_lsb +: 8] = din;
            if (cnt_q == 4'd15) begin
              cnt_d       = 4'd0;
              state_d     = EMIT;
              blk_out_d   = asm_d;
              blk_type_d  = type_q;
              blk_valid_d = 1'b1;
              blk_count_d = CNT_W'(blk_count + 1'b1);
            end else begin
              cnt_d = 4'(cnt_q + 4'd1);
            end
          end
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: framing-error vector table plus
// hand-written block sequences (latency, restart, reset, counter wrap).
module tb_aes_block_loader;

  localparam logic [1:0] K = 2'b10;
  localparam logic [1:0] D = 2'b01;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   din = 8'd0;
  logic         din_valid = 1'b0;
  logic         din_first = 1'b0;
  logic [1:0]   din_type = 2'b00;
  logic         din_ready;
  logic [127:0] blk_out;
  logic [1:0]   blk_type;
  logic         blk_valid;
  logic         err;
  logic [7:0]   blk_count;

  int errors = 0;
  int checks = 0;

  aes_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_first (din_first),
    .din_type  (din_type),
    .din_ready (din_ready),
    .blk_out   (blk_out),
    .blk_type  (blk_type),
    .blk_valid (blk_valid),
    .err       (err),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       f;
    logic [1:0] t;
    logic [7:0] d;
    logic       exp_rdy;
    logic       exp_err;
    logic       exp_bv;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic f, input logic [1:0] t, input logic [7:0] d);
    din_valid = v;
    din_first = f;
    din_type  = t;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_first = 1'b0;
  endtask

  function automatic logic [127:0] make_blk(input logic [7:0] base);
    logic [127:0] b;
    b = 128'd0;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'(base + 8'(i));
    return b;
  endfunction

  // Contiguous 16-byte block; counts err pulses and premature blk_valid.
  task automatic send_block(input logic [1:0] t, input logic [7:0] base,
                            output int errs, output int early);
    errs  = 0;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, (i == 0), t, 8'(base + 8'(i)));
      if (err) errs++;
      if (i < 15 && blk_valid) early++;
    end
  endtask

  initial begin
    int errs, early, seen, idx;
    logic v;

    vecs[0] = '{1'b1, 1'b0, K,     8'hAA, 1'b1, 1'b1, 1'b0}; // no start in IDLE
    vecs[1] = '{1'b1, 1'b1, 2'b11, 8'hBB, 1'b1, 1'b1, 1'b0}; // illegal type
    vecs[2] = '{1'b0, 1'b0, K,     8'h00, 1'b1, 1'b0, 1'b0}; // gap
    vecs[3] = '{1'b1, 1'b1, 2'b00, 8'hCC, 1'b1, 1'b1, 1'b0}; // illegal type 00
    vecs[4] = '{1'b1, 1'b1, K,     8'h11, 1'b1, 1'b0, 1'b0}; // legal start
    vecs[5] = '{1'b1, 1'b0, D,     8'h22, 1'b1, 1'b1, 1'b0}; // type mismatch
    vecs[6] = '{1'b1, 1'b0, K,     8'h33, 1'b1, 1'b1, 1'b0}; // back in IDLE, no start
    vecs[7] = '{1'b0, 1'b0, K,     8'h00, 1'b1, 1'b0, 1'b0}; // gap

    // Reset state while rst is held
    #12;
    check("rst_blk_out",   blk_out,   128'd0);
    check("rst_blk_type",  128'(blk_type), 128'd0);
    check("rst_blk_valid", 128'(blk_valid), 128'd0);
    check("rst_err",       128'(err), 128'd0);
    check("rst_blk_count", 128'(blk_count), 128'd0);
    check("rst_din_ready", 128'(din_ready), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Contiguous key block 00..0F
    send_block(K, 8'h00, errs, early);
    check("t1_valid",   128'(blk_valid), 128'd1);
    check("t1_blk_out", blk_out, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_type",    128'(blk_type), 128'(K));
    check("t1_count",   128'(blk_count), 128'd1);
    check("t1_ready",   128'(din_ready), 128'd0);
    check("t1_errs",    128'(errs), 128'd0);
    check("t1_early",   128'(early), 128'd0);
    // Byte offered during EMIT must be ignored without err
    cyc(1'b1, 1'b1, K, 8'h77);
    check("emit_ign_err",   128'(err), 128'd0);
    check("emit_ign_valid", 128'(blk_valid), 128'd0);
    check("emit_ready",     128'(din_ready), 128'd1);

    // Data block with din_valid toggling every cycle
    idx  = 0;
    seen = -1;
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      v = ((c % 2) == 0) && (idx < 16);
      cyc(v, v && (idx == 0), D, 8'(idx));
      if (v) idx++;
      if (err) errs++;
      if (blk_valid) begin
        seen = c;
        break;
      end
    end
    check("t2_latency", 128'(seen), 128'd30);
    check("t2_blk_out", blk_out, make_blk(8'h00));
    check("t2_type",    128'(blk_type), 128'(D));
    check("t2_count",   128'(blk_count), 128'd2);
    check("t2_errs",    128'(errs), 128'd0);
    cyc(1'b0, 1'b0, K, 8'h00);

    // Framing-error vector table
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec%0d_ready", i), 128'(din_ready), 128'(vecs[i].exp_rdy));
      cyc(vecs[i].v, vecs[i].f, vecs[i].t, vecs[i].d);
      check($sformatf("vec%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
      check($sformatf("vec%0d_valid", i), 128'(blk_valid), 128'(vecs[i].exp_bv));
    end
    check("t3_blk_out_held", blk_out, make_blk(8'h00));
    check("t3_type_held",    128'(blk_type), 128'(D));
    check("t3_count_held",   128'(blk_count), 128'd2);

    // Restart after 5 bytes of a key block
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 0), K, 8'(8'hA0 + 8'(i)));
      if (err) errs++;
    end
    check("t4_pre_errs", 128'(errs), 128'd0);
    cyc(1'b1, 1'b1, K, 8'h50);
    check("t4_restart_err", 128'(err), 128'd1);
    errs  = 0;
    early = 0;
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, K, 8'(8'h50 + 8'(i)));
      if (err) errs++;
      if (i < 15 && blk_valid) early++;
    end
    check("t4_valid",   128'(blk_valid), 128'd1);
    check("t4_blk_out", blk_out, make_blk(8'h50));
    check("t4_type",    128'(blk_type), 128'(K));
    check("t4_count",   128'(blk_count), 128'd3);
    check("t4_errs",    128'(errs), 128'd0);
    check("t4_early",   128'(early), 128'd0);
    cyc(1'b0, 1'b0, K, 8'h00);

    // Type mismatch at byte 10, then a clean data block
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 0), K, 8'(8'hC0 + 8'(i)));
    cyc(1'b1, 1'b0, D, 8'hFF);
    check("t5_mismatch_err", 128'(err), 128'd1);
    cyc(1'b0, 1'b0, K, 8'h00);
    send_block(D, 8'h30, errs, early);
    check("t5_valid",   128'(blk_valid), 128'd1);
    check("t5_blk_out", blk_out, make_blk(8'h30));
    check("t5_type",    128'(blk_type), 128'(D));
    check("t5_count",   128'(blk_count), 128'd4);
    check("t5_errs",    128'(errs + early), 128'd0);
    cyc(1'b0, 1'b0, K, 8'h00);

    // Asynchronous reset mid-block clears outputs at once
    for (int i = 0; i < 8; i++) cyc(1'b1, (i == 0), K, 8'(8'h80 + 8'(i)));
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_blk_out", blk_out, 128'd0);
    check("t6_rst_type",    128'(blk_type), 128'd0);
    check("t6_rst_count",   128'(blk_count), 128'd0);
    check("t6_rst_ready",   128'(din_ready), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_block(K, 8'h40, errs, early);
    check("t6_valid",   128'(blk_valid), 128'd1);
    check("t6_blk_out", blk_out, make_blk(8'h40));
    check("t6_count",   128'(blk_count), 128'd1);
    check("t6_errs",    128'(errs + early), 128'd0);
    cyc(1'b0, 1'b0, K, 8'h00);

    // Counter wrap: 255 blocks total, then the 256th wraps to 0
    for (int b = 0; b < 254; b++) begin
      send_block(D, 8'(b), errs, early);
      cyc(1'b0, 1'b0, K, 8'h00);
    end
    check("wrap_count_255", 128'(blk_count), 128'd255);
    send_block(K, 8'h10, errs, early);
    check("wrap_valid", 128'(blk_valid), 128'd1);
    check("wrap_count_0", 128'(blk_count), 128'd0);
    check("wrap_blk_out", blk_out, make_blk(8'h10));
    cyc(1'b0, 1'b0, K, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Byte-serial input stage directly upstream of key expansion and the cipher datapath.
- Assembles 16 input bytes into one 128-bit block and tags it with a 2-bit type (key or data).
- Presents the block with a one-cycle valid pulse on the key_in / key_in_valid / key_in_type style interface.
- Flags framing errors: missing start byte, type change inside a block, illegal type.

Parameters:
- TYPE_KEY, 2'b10, type code for a cipher key block.
- TYPE_DATA, 2'b01, type code for a plaintext/data block.
- CNT_W, 8, width of the completed-block counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset).
- din  in  8  input byte.
- din_valid  in  1  din, din_first and din_type are valid this cycle.
- din_first  in  1  this byte is byte 0 of a new block.
- din_type  in  2  type of the block being transferred.
- din_ready  out  1  loader accepts a byte this cycle.
- blk_out  out  128  assembled block. Byte k occupies bits [8k+7:8k], so byte 0 (first received) is bits [7:0].
- blk_type  out  2  type of blk_out.
- blk_valid  out  1  one-cycle pulse: blk_out and blk_type are new.
- err  out  1  one-cycle pulse on a framing error.
- blk_count  out  CNT_W  number of blocks emitted, wraps.

Behaviour:
- A byte is accepted when din_valid && din_ready.
- Reset values: state IDLE, byte counter 0, assembly register 0, blk_out 0, blk_type 2'b00, blk_valid 0, err 0, blk_count 0.
- din_ready is combinational: 1 in IDLE and COLLECT, 0 in EMIT. It is therefore 1 while reset is held.
- IDLE:
  - Accepted byte with din_first=1 and din_type in {TYPE_KEY, TYPE_DATA}: store at byte 0, latch type, cnt <= 1, go to COLLECT.
  - Accepted byte with din_first=0, or with an illegal type: byte dropped, err pulses next cycle, stay IDLE.
- COLLECT:
  - Accepted byte with din_first=0 and din_type equal to the latched type: store at byte position cnt, cnt <= cnt+1.
  - If that byte was byte 15 (cnt==15), go to EMIT and cnt <= 0.
  - Accepted byte with din_first=1 and a legal type: partial block discarded, err pulses, byte stored as byte 0 of a new block, new type latched, cnt <= 1, stay COLLECT.
  - Accepted byte with din_first=1 and an illegal type: partial block discarded, err pulses, go to IDLE, byte dropped.
  - Accepted byte with din_first=0 and a type mismatch: byte dropped, partial block discarded, err pulses, go to IDLE.
  - No accepted byte: hold everything. Gaps in din_valid are allowed at any point.
- EMIT (exactly one cycle):
  - blk_valid=1; blk_out and blk_type show the new block.
  - blk_count <= blk_count+1, wrapping from 2^CNT_W-1 to 0.
  - din_ready=0; any din_valid this cycle is ignored, with no err.
  - Next state IDLE.
- blk_out and blk_type are registered and hold their last emitted value until the next EMIT. Partial assembly never disturbs them.
- Latency: last byte accepted on edge N; blk_valid high during the cycle after edge N. Minimum block period is 17 cycles (16 bytes plus 1 EMIT bubble).
- err is a registered single-cycle pulse in the cycle after the offending byte. Multiple errors on consecutive cycles give consecutive pulses.
- Reset asserted mid-block: partial data lost and all outputs return to reset values immediately (asynchronous). The first accepted byte after release must carry din_first=1.
- Byte-position writes are indexed by cnt only. Unwritten byte positions of the assembly register keep stale data but are always overwritten before EMIT.

Test Plan:
- Reset release, then 16 contiguous TYPE_KEY bytes 0x00..0x0F with din_first on byte 0 -> one cycle after the last byte, blk_valid=1, blk_out=128'h0F0E0D0C0B0A09080706050403020100, blk_type=2'b10, blk_count=1; din_ready=0 in that cycle only.
- Same TYPE_DATA block with din_valid toggling 1/0 every cycle -> identical blk_out, blk_type=2'b01, blk_valid 31 cycles after the first byte.
- Byte with din_first=0 in IDLE, then a byte with din_type=2'b11 and din_first=1 -> two err pulses, no blk_valid, blk_out stays at its previous value.
- 5 bytes of a key block, then din_first=1 with a legal type, then 15 more bytes -> one err pulse at the restart; the emitted block contains only the post-restart 16 bytes.
- Key block 10 bytes in, then one byte with a mismatched type -> err pulse, return to IDLE; a following full block emits normally.
- Reset asserted at byte 8 -> outputs cleared immediately. A full block after release emits with blk_count=1. Emitting 256 blocks with CNT_W=8 -> blk_count wraps to 0.
